// File: rtl/control_necesidades_if.sv
// Signal bundle between the needs sequencer and its surroundings:
// debounced buttons/sensors and tracker levels in, tracker controls and status out.
interface control_necesidades_if;
  logic       test;
  logic       b_energia;
  logic       b_medicina;
  logic       oscuro;
  logic       sensor_animo;
  logic [1:0] nivel_animo;
  logic [1:0] nivel_energia;
  logic [1:0] nivel_descanso;
  logic [1:0] nivel_medicina;
  logic       entrada_animo;
  logic       entrada_energia;
  logic       entrada_descanso;
  logic       entrada_medicina;
  logic       activo_animo;
  logic       activo_energia;
  logic       activo_descanso;
  logic       activo_medicina;
  logic       tick;
  logic       modo_test;
  logic [2:0] estado;
  logic       muerto;

  modport slave (
    input  test, b_energia, b_medicina, oscuro, sensor_animo,
           nivel_animo, nivel_energia, nivel_descanso, nivel_medicina,
    output entrada_animo, entrada_energia, entrada_descanso, entrada_medicina,
           activo_animo, activo_energia, activo_descanso, activo_medicina,
           tick, modo_test, estado, muerto
  );

  modport master (
    output test, b_energia, b_medicina, oscuro, sensor_animo,
           nivel_animo, nivel_energia, nivel_descanso, nivel_medicina,
    input  entrada_animo, entrada_energia, entrada_descanso, entrada_medicina,
           activo_animo, activo_energia, activo_descanso, activo_medicina,
           tick, modo_test, estado, muerto
  );
endinterface

// File: rtl/control_necesidades.sv
// Virtual-pet needs sequencer: owns the tick time base, picks which need is
// served, queues button requests that arrive while busy and detects death.
module control_necesidades #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TEST_DIV = 50_000,
  parameter int ACCION_S = 5
) (
  input logic                  clk,
  input logic                  reset,
  control_necesidades_if.slave io
);
  localparam int DIV_MAX = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int T_W     = (ACCION_S > 1) ? $clog2(ACCION_S) : 1;
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] TEST_LAST = DIV_W'(TEST_DIV - 1);
  localparam logic [T_W-1:0]   T_LAST    = T_W'(ACCION_S - 1);

  typedef enum logic [2:0] {
    NORMAL    = 3'd0,
    COMIENDO  = 3'd1,
    CURANDO   = 3'd2,
    DURMIENDO = 3'd3,
    JUGANDO   = 3'd4,
    MUERTO    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             modo_test_q, modo_test_d;
  logic [T_W-1:0]   t_q, t_d;
  logic             pend_med_q, pend_med_d;
  logic             pend_ener_q, pend_ener_d;
  logic             sens_prev_q, sens_prev_d;
  // Bit order of both vectors: {medicina, descanso, energia, animo}
  logic [3:0]       entrada_q, entrada_d;
  logic [3:0]       activo_q, activo_d;
  logic [2:0]       zeros;
  logic             muerte;
  logic             flanco;

  always_comb begin
    modo_test_d = modo_test_q;
    div_d       = div_q + 1'b1;
    tick_d      = 1'b0;
    sens_prev_d = io.sensor_animo;
    if (io.test) begin
      modo_test_d = ~modo_test_q;
      div_d       = '0;
    end else if (div_q == (modo_test_q ? TEST_LAST : TICK_LAST)) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_comb begin
    zeros = {2'b00, io.nivel_animo    == 2'd0}
          + {2'b00, io.nivel_energia  == 2'd0}
          + {2'b00, io.nivel_descanso == 2'd0}
          + {2'b00, io.nivel_medicina == 2'd0};
    muerte = (zeros >= 3'd3);
    flanco = io.sensor_animo & ~sens_prev_q;
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    pend_med_d  = pend_med_q;
    pend_ener_d = pend_ener_q;
    if (state_q != MUERTO && muerte) begin
      state_d     = MUERTO;
      pend_med_d  = 1'b0;
      pend_ener_d = 1'b0;
    end else begin
      case (state_q)
        NORMAL: begin
          // Holding t at zero here is what clears it on entry to any action.
          t_d = '0;
          if (io.b_medicina || pend_med_q) begin
            state_d    = CURANDO;
            pend_med_d = 1'b0;
            if (io.b_energia) pend_ener_d = 1'b1;
          end else if (io.b_energia || pend_ener_q) begin
            state_d     = COMIENDO;
            pend_ener_d = 1'b0;
          end else if (io.oscuro) begin
            state_d = DURMIENDO;
          end else if (flanco) begin
            state_d = JUGANDO;
          end
        end
        COMIENDO, CURANDO, JUGANDO: begin
          if (io.b_medicina) pend_med_d  = 1'b1;
          if (io.b_energia)  pend_ener_d = 1'b1;
          if (tick_q) begin
            if (t_q == T_LAST) state_d = NORMAL;
            else               t_d     = t_q + 1'b1;
          end
        end
        DURMIENDO: begin
          if (io.b_medicina) pend_med_d  = 1'b1;
          if (io.b_energia)  pend_ener_d = 1'b1;
          if (!io.oscuro || (io.nivel_descanso == 2'd3 && tick_q)) state_d = NORMAL;
        end
        MUERTO: ;
        default: state_d = NORMAL;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with estado.
  always_comb begin
    entrada_d = 4'b0000;
    activo_d  = 4'b1111;
    case (state_d)
      COMIENDO:  entrada_d[1] = 1'b1;
      CURANDO:   entrada_d[3] = 1'b1;
      JUGANDO:   entrada_d[0] = 1'b1;
      DURMIENDO: begin
        entrada_d[2] = 1'b1;
        activo_d[0]  = 1'b0;
      end
      MUERTO:    activo_d = 4'b0000;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= NORMAL;
      div_q       <= '0;
      tick_q      <= 1'b0;
      modo_test_q <= 1'b0;
      t_q         <= '0;
      pend_med_q  <= 1'b0;
      pend_ener_q <= 1'b0;
      sens_prev_q <= 1'b0;
      entrada_q   <= 4'b0000;
      activo_q    <= 4'b1111;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      modo_test_q <= modo_test_d;
      t_q         <= t_d;
      pend_med_q  <= pend_med_d;
      pend_ener_q <= pend_ener_d;
      sens_prev_q <= sens_prev_d;
      entrada_q   <= entrada_d;
      activo_q    <= activo_d;
    end
  end

  assign io.entrada_animo    = entrada_q[0];
  assign io.entrada_energia  = entrada_q[1];
  assign io.entrada_descanso = entrada_q[2];
  assign io.entrada_medicina = entrada_q[3];
  assign io.activo_animo     = activo_q[0];
  assign io.activo_energia   = activo_q[1];
  assign io.activo_descanso  = activo_q[2];
  assign io.activo_medicina  = activo_q[3];
  assign io.tick             = tick_q;
  assign io.modo_test        = modo_test_q;
  assign io.estado           = state_q;
  assign io.muerto           = (state_q == MUERTO);
endmodule

// File: tb/tb_control_necesidades.sv
// Bench for control_necesidades: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the needs sequencer.
module tb_control_necesidades;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   tk;

  // Reference model state (plain integers, state codes as in the datasheet)
  int m_state, m_div, m_tick, m_test, m_t, m_pm, m_pe, m_prev;

  control_necesidades_if io ();

  control_necesidades #(
    .TICK_DIV(10),
    .TEST_DIV(2),
    .ACCION_S(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_div = 0; m_tick = 0; m_test = 0;
    m_t = 0; m_pm = 0; m_pe = 0; m_prev = 0;
  endtask

  task automatic model_step();
    int ns, nt, npm, npe, ndiv, ntick, ntest, zeros, period;
    bit rise;
    if (!reset) begin
      model_reset();
      return;
    end
    period = m_test ? 2 : 10;
    if (io.test) begin
      ntest = 1 - m_test; ndiv = 0; ntick = 0;
    end else begin
      ntest = m_test;
      ntick = (m_div == period - 1);
      ndiv  = ntick ? 0 : m_div + 1;
    end
    zeros = int'(io.nivel_animo == 0) + int'(io.nivel_energia == 0)
          + int'(io.nivel_descanso == 0) + int'(io.nivel_medicina == 0);
    rise = io.sensor_animo && !m_prev;
    ns = m_state; nt = m_t; npm = m_pm; npe = m_pe;
    if (m_state != 5 && zeros >= 3) begin
      ns = 5; npm = 0; npe = 0;
    end else if (m_state == 0) begin
      if (io.b_medicina || m_pm != 0) begin
        ns = 2; npm = 0;
        if (io.b_energia) npe = 1;
      end else if (io.b_energia || m_pe != 0) begin
        ns = 1; npe = 0;
      end else if (io.oscuro) ns = 3;
      else if (rise) ns = 4;
      nt = 0;
    end else if (m_state != 5) begin
      if (io.b_medicina) npm = 1;
      if (io.b_energia)  npe = 1;
      if (m_state == 3) begin
        if (!io.oscuro || (io.nivel_descanso == 3 && m_tick != 0)) ns = 0;
      end else if (m_tick != 0) begin
        if (m_t == 2) ns = 0;
        else nt = m_t + 1;
      end
    end
    m_state = ns; m_t = nt; m_pm = npm; m_pe = npe;
    m_div = ndiv; m_tick = ntick; m_test = ntest;
    m_prev = int'(io.sensor_animo);
  endtask

  function automatic logic [13:0] dut_outs();
    return {io.estado, io.muerto, io.modo_test, io.tick,
            io.entrada_medicina, io.entrada_descanso, io.entrada_energia, io.entrada_animo,
            io.activo_medicina, io.activo_descanso, io.activo_energia, io.activo_animo};
  endfunction

  function automatic logic [13:0] model_outs();
    logic [3:0] ent, act;
    ent = {m_state == 2, m_state == 3, m_state == 1, m_state == 4};
    act = (m_state == 5) ? 4'b0000 : (m_state == 3) ? 4'b1110 : 4'b1111;
    return {3'(m_state), m_state == 5, m_test != 0, m_tick != 0, ent, act};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("outs", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic wait_estado(input string tag, input int st, output int ticks);
    int n;
    n = 0;
    ticks = 0;
    while (int'(io.estado) != st && n < 100) begin
      if (io.tick) ticks++;
      cyc();
      n++;
    end
    chk(tag, 32'(io.estado), 32'(st));
  endtask

  task automatic set_levels(input int a, input int e, input int d, input int m);
    io.nivel_animo    = 2'(a);
    io.nivel_energia  = 2'(e);
    io.nivel_descanso = 2'(d);
    io.nivel_medicina = 2'(m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b0;
    io.test = 1'b0; io.b_energia = 1'b0; io.b_medicina = 1'b0;
    io.oscuro = 1'b0; io.sensor_animo = 1'b0;
    set_levels(3, 3, 3, 3);
    model_reset();
    cyc();
    cyc();
    chk("rst_estado", 32'(io.estado), 32'd0);
    chk("rst_activo", 32'({io.activo_medicina, io.activo_descanso, io.activo_energia, io.activo_animo}), 32'hF);
    reset = 1'b1;

    // Time base, normal then accelerated
    for (int i = 1; i <= 35; i++) begin
      cyc();
      chk("tick_norm", 32'(io.tick), 32'((i % 10) == 0));
    end
    io.test = 1'b1;
    cyc();
    io.test = 1'b0;
    chk("modo_test", 32'(io.modo_test), 32'd1);
    cyc();
    chk("tick_fast1", 32'(io.tick), 32'd0);
    cyc();
    chk("tick_fast2", 32'(io.tick), 32'd1);

    // Single feed
    io.b_energia = 1'b1;
    cyc();
    io.b_energia = 1'b0;
    chk("feed_estado", 32'(io.estado), 32'd1);
    chk("feed_entrada", 32'(io.entrada_energia), 32'd1);
    chk("feed_activo", 32'({io.activo_medicina, io.activo_descanso, io.activo_energia, io.activo_animo}), 32'hF);
    wait_estado("feed_exit", 0, tk);
    chk("feed_ticks", 32'(tk), 32'd3);

    // Simultaneous requests, extra feed presses while curing
    io.b_medicina = 1'b1; io.b_energia = 1'b1;
    cyc();
    io.b_medicina = 1'b0; io.b_energia = 1'b0;
    chk("queue_cur", 32'(io.estado), 32'd2);
    for (int i = 0; i < 2; i++) begin
      io.b_energia = 1'b1;
      cyc();
      io.b_energia = 1'b0;
      cyc();
    end
    wait_estado("cur_exit", 0, tk);
    cyc();
    chk("queue_com", 32'(io.estado), 32'd1);
    wait_estado("com_exit", 0, tk);
    chk("com_ticks", 32'(tk), 32'd3);
    for (int i = 0; i < 10; i++) cyc();
    chk("queue_once", 32'(io.estado), 32'd0);

    // Sleep: leave on a full-rest tick, then on light
    io.oscuro = 1'b1;
    cyc();
    chk("sleep_estado", 32'(io.estado), 32'd3);
    chk("sleep_entrada", 32'(io.entrada_descanso), 32'd1);
    chk("sleep_animo_off", 32'(io.activo_animo), 32'd0);
    wait_estado("sleep_tick_exit", 0, tk);
    chk("sleep_ticks", 32'(tk), 32'd1);
    io.nivel_descanso = 2'd2;
    cyc();
    chk("sleep_again", 32'(io.estado), 32'd3);
    io.oscuro = 1'b0;
    cyc();
    chk("wake", 32'(io.estado), 32'd0);

    // Play on the rising edge only
    io.sensor_animo = 1'b1;
    cyc();
    chk("play_estado", 32'(io.estado), 32'd4);
    wait_estado("play_exit", 0, tk);
    chk("play_ticks", 32'(tk), 32'd3);
    for (int i = 0; i < 8; i++) cyc();
    chk("play_once", 32'(io.estado), 32'd0);
    io.sensor_animo = 1'b0;
    cyc();
    io.sensor_animo = 1'b1;
    cyc();
    chk("play_again", 32'(io.estado), 32'd4);
    wait_estado("play_exit2", 0, tk);
    io.sensor_animo = 1'b0;

    // Death during an action
    io.b_energia = 1'b1;
    cyc();
    io.b_energia = 1'b0;
    set_levels(0, 0, 2, 0);
    cyc();
    chk("dead_estado", 32'(io.estado), 32'd5);
    chk("dead_muerto", 32'(io.muerto), 32'd1);
    chk("dead_ctrl", 32'({io.entrada_medicina, io.entrada_descanso, io.entrada_energia, io.entrada_animo,
                          io.activo_medicina, io.activo_descanso, io.activo_energia, io.activo_animo}), 32'd0);
    set_levels(3, 3, 3, 3);
    io.b_medicina = 1'b1; io.b_energia = 1'b1;
    cyc();
    io.b_medicina = 1'b0; io.b_energia = 1'b0;
    cyc();
    chk("dead_stays", 32'(io.estado), 32'd5);
    reset = 1'b0;
    model_reset();
    #1;
    chk("dead_reset_estado", 32'(io.estado), 32'd0);
    chk("dead_reset_outs", 32'(dut_outs()), 32'(model_outs()));
    cyc();
    reset = 1'b1;

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      reset = 1'b1;
      io.b_energia  = ($urandom_range(0, 9) == 0);
      io.b_medicina = ($urandom_range(0, 11) == 0);
      io.test       = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) io.oscuro = ~io.oscuro;
      if ($urandom_range(0, 7) == 0) io.sensor_animo = ~io.sensor_animo;
      if ($urandom_range(0, 9) == 0)
        set_levels(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3)),
                   ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3)),
                   ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3)),
                   ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3)));
      if ($urandom_range(0, 299) == 0 || (m_state == 5 && $urandom_range(0, 19) == 0)) begin
        reset = 1'b0;
        model_reset();
        #1;
        chk("rnd_async_rst", 32'(dut_outs()), 32'(model_outs()));
      end
      cyc();
    end
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
